// File: rtl/vga_frame_latch.sv
// Double-buffered display register bank: the processor writes a shadow bank, and on request
// the whole bank is copied to the active bank at the next vertical-sync falling edge.
module vga_frame_latch #(
    parameter int NUM_FRAMES_W = 16
) (
    input  logic                    iVGA_CLK,
    input  logic                    reset,
    input  logic                    iVS,
    input  logic                    wr_en,
    input  logic [3:0]              wr_addr,
    input  logic [31:0]             wr_data,
    input  logic [3:0]              rd_addr,
    output logic [31:0]             rd_data,
    output logic [31:0]             block1x,
    output logic [31:0]             block1y,
    output logic [31:0]             block2x,
    output logic [31:0]             block2y,
    output logic [31:0]             block3x,
    output logic [31:0]             block3y,
    output logic [31:0]             block4x,
    output logic [31:0]             block4y,
    output logic [31:0]             score,
    output logic [31:0]             blockType,
    output logic [31:0]             screenMode,
    output logic [15:0]             sysTime,
    output logic                    commit_pending,
    output logic                    commit_done,
    output logic [NUM_FRAMES_W-1:0] frame_count
);

    // state   | meaning
    // IDLE    | no commit outstanding
    // PENDING | commit requested, waiting for a frame boundary
    // COMMIT  | active bank was just loaded from the shadow bank
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        vs_q;
    logic        frame_edge;
    logic        commit_req;
    logic        copy_en;
    logic [7:0]  overrun;
    logic [15:0] fc16;
    logic [31:0] status;
    logic [31:0] rd_next;
    logic [31:0] shadow [12];
    logic [31:0] active [12];

    assign frame_edge = vs_q & ~iVS;
    assign commit_req = wr_en && (wr_addr == 4'd12);
    assign copy_en    = (state_q == PENDING) && frame_edge;
    assign fc16       = 16'(frame_count);
    assign status     = {overrun, 6'b0, state_q, fc16};

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vs_q        <= 1'b1;
            frame_count <= '0;
            overrun     <= 8'd0;
        end else begin
            state_q <= state_d;
            vs_q    <= iVS;
            if (frame_edge)
                frame_count <= frame_count + {{(NUM_FRAMES_W-1){1'b0}}, 1'b1};
            if ((state_q == PENDING) && commit_req && (overrun != 8'hFF))
                overrun <= overrun + 8'd1;
        end
    end

    // A request merged while pending still leaves on the boundary; the merge only counts.
    always_comb begin
        state_d        = state_q;
        commit_pending = 1'b0;
        commit_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req)
                    state_d = PENDING;
            end
            PENDING: begin
                commit_pending = 1'b1;
                if (frame_edge)
                    state_d = COMMIT;
            end
            COMMIT: begin
                commit_done = 1'b1;
                state_d     = commit_req ? PENDING : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The copy samples shadow before this edge's write lands, so a same-cycle write stays shadow-only.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 12; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (copy_en) begin
                for (int i = 0; i < 12; i++)
                    active[i] <= shadow[i];
            end
            if (wr_en && (wr_addr < 4'd12))
                shadow[wr_addr] <= (wr_addr == 4'd11) ? {16'b0, wr_data[15:0]} : wr_data;
        end
    end

    always_comb begin
        rd_next = '0;
        if (rd_addr < 4'd12)
            rd_next = shadow[rd_addr];
        else if (rd_addr == 4'd12)
            rd_next = status;
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= rd_next;
    end

    assign block1x    = active[0];
    assign block1y    = active[1];
    assign block2x    = active[2];
    assign block2y    = active[3];
    assign block3x    = active[4];
    assign block3y    = active[5];
    assign block4x    = active[6];
    assign block4y    = active[7];
    assign score      = active[8];
    assign blockType  = active[9];
    assign screenMode = active[10];
    assign sysTime    = active[11][15:0];

endmodule

// File: tb/tb_vga_frame_latch.sv
// Bench for vga_frame_latch: vector table, corner-case sequences and a randomized run,
// all compared against a register-bank model updated once per clock.
module tb_vga_frame_latch;

    logic        iVGA_CLK = 1'b0;
    logic        reset = 1'b1;
    logic        iVS = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [31:0] block1x, block1y, block2x, block2y, block3x, block3y, block4x, block4y;
    logic [31:0] score, blockType, screenMode;
    logic [15:0] sysTime;
    logic        commit_pending, commit_done;
    logic [15:0] frame_count;

    int total = 0;
    int bad = 0;

    vga_frame_latch #(.NUM_FRAMES_W(16)) dut (
        .iVGA_CLK(iVGA_CLK), .reset(reset), .iVS(iVS),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .block1x(block1x), .block1y(block1y), .block2x(block2x), .block2y(block2y),
        .block3x(block3x), .block3y(block3y), .block4x(block4x), .block4y(block4y),
        .score(score), .blockType(blockType), .screenMode(screenMode), .sysTime(sysTime),
        .commit_pending(commit_pending), .commit_done(commit_done), .frame_count(frame_count)
    );

    always #20 iVGA_CLK = ~iVGA_CLK;

    // Reference model: a pending flag and a "just copied" flag describe the request lifecycle.
    logic [31:0] m_shadow [12];
    logic [31:0] m_active [12];
    bit          m_pend, m_done, m_vsp;
    int          m_fc, m_ovr;
    logic [31:0] m_rd;

    task automatic model_reset();
        for (int i = 0; i < 12; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_pend = 0; m_done = 0; m_vsp = 1; m_fc = 0; m_ovr = 0; m_rd = '0;
    endtask

    task automatic model_step();
        bit boundary, req, nxt_pend, nxt_done;
        int st;
        boundary = m_vsp && !iVS;
        req = wr_en && (wr_addr == 4'd12);
        st = m_pend ? 1 : (m_done ? 2 : 0);
        if (rd_addr < 12)       m_rd = m_shadow[rd_addr];
        else if (rd_addr == 12) m_rd = 32'((m_ovr << 24) + (st << 16) + m_fc);
        else                    m_rd = '0;
        if (m_pend && boundary)
            for (int i = 0; i < 12; i++) m_active[i] = m_shadow[i];
        if (wr_en && wr_addr < 12)
            m_shadow[wr_addr] = (wr_addr == 11) ? (wr_data & 32'h0000FFFF) : wr_data;
        if (m_pend && req && m_ovr < 255) m_ovr++;
        nxt_done = m_pend && boundary;
        nxt_pend = m_pend ? !boundary : req;
        m_pend = nxt_pend;
        m_done = nxt_done;
        if (boundary) m_fc = (m_fc + 1) % 65536;
        m_vsp = iVS;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] a [12];
        a[0] = block1x; a[1] = block1y; a[2] = block2x; a[3] = block2y;
        a[4] = block3x; a[5] = block3y; a[6] = block4x; a[7] = block4y;
        a[8] = score;   a[9] = blockType; a[10] = screenMode; a[11] = {16'b0, sysTime};
        for (int i = 0; i < 12; i++) chk($sformatf("model_active[%0d]", i), a[i], m_active[i]);
        chk("model_rd_data", rd_data, m_rd);
        chk("model_pending", 32'(commit_pending), 32'(m_pend));
        chk("model_done", 32'(commit_done), 32'(m_done));
        chk("model_frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic cycle();
        if (reset) model_reset(); else model_step();
        @(posedge iVGA_CLK);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; iVS = 1'b1; rd_addr = '0;
        #1;
        model_reset();
        chk("reset_pending", 32'(commit_pending), 32'd0);
        chk("reset_done", 32'(commit_done), 32'd0);
        chk("reset_frame_count", 32'(frame_count), 32'd0);
        chk("reset_screenMode", screenMode, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic frame();
        iVS = 1'b0; cycle();
        iVS = 1'b1; cycle();
    endtask

    typedef struct {
        bit          vs;
        bit          we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        bit          e_pend;
        bit          e_done;
        logic [31:0] e_b1x;
        logic [15:0] e_sys;
        logic [31:0] e_rd;
        int          e_fc;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1, 1, 4'd0,  32'd5,         4'd0,  0, 0, 32'd0, 16'h0000, 32'h0,        0};
        tbl[1] = '{1, 1, 4'd11, 32'hABCD1234,  4'd0,  0, 0, 32'd0, 16'h0000, 32'd5,        0};
        tbl[2] = '{1, 1, 4'd12, 32'hFFFFFFFF,  4'd11, 1, 0, 32'd0, 16'h0000, 32'h00001234, 0};
        tbl[3] = '{1, 0, 4'd0,  32'd0,         4'd12, 1, 0, 32'd0, 16'h0000, 32'h00010000, 0};
        tbl[4] = '{0, 0, 4'd0,  32'd0,         4'd12, 0, 1, 32'd5, 16'h1234, 32'h00010000, 1};
        tbl[5] = '{0, 0, 4'd0,  32'd0,         4'd12, 0, 0, 32'd5, 16'h1234, 32'h00020001, 1};
        tbl[6] = '{1, 0, 4'd0,  32'd0,         4'd0,  0, 0, 32'd5, 16'h1234, 32'd5,        1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            iVS = tbl[i].vs; wr_en = tbl[i].we; wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd; rd_addr = tbl[i].ra;
            cycle();
            chk($sformatf("vec%0d_pending", i), 32'(commit_pending), 32'(tbl[i].e_pend));
            chk($sformatf("vec%0d_done", i), 32'(commit_done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d_block1x", i), block1x, tbl[i].e_b1x);
            chk($sformatf("vec%0d_sysTime", i), 32'(sysTime), 32'(tbl[i].e_sys));
            chk($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].e_rd);
            chk($sformatf("vec%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].e_fc));
        end
        wr_en = 1'b0; iVS = 1'b1;

        // Shadow write with no commit never reaches the display.
        do_reset();
        write(4'd10, 32'h20000000);
        repeat (3) frame();
        chk("nocommit_screenMode", screenMode, 32'd0);
        chk("nocommit_frame_count", 32'(frame_count), 32'd3);

        // Merged requests and overrun saturation.
        do_reset();
        wr_en = 1'b1; wr_addr = 4'd12;
        repeat (3) cycle();
        wr_en = 1'b0; rd_addr = 4'd12;
        cycle();
        chk("merge3_overrun", 32'(rd_data[31:24]), 32'd2);
        iVS = 1'b0; cycle();
        chk("merge3_done", 32'(commit_done), 32'd1);
        iVS = 1'b1; cycle();
        chk("merge3_done_clear", 32'(commit_done), 32'd0);
        wr_en = 1'b1; wr_addr = 4'd12;
        repeat (301) cycle();
        wr_en = 1'b0;
        cycle();
        chk("overrun_saturate", 32'(rd_data[31:24]), 32'd255);

        // Request on the boundary cycle waits for the next one; same-cycle write stays in shadow.
        do_reset();
        write(4'd8, 32'h11);
        write(4'd12, 32'h0);
        frame();
        chk("score_first", score, 32'h11);
        iVS = 1'b0; wr_en = 1'b1; wr_addr = 4'd12;
        cycle();
        chk("edge_req_pending", 32'(commit_pending), 32'd1);
        chk("edge_req_no_done", 32'(commit_done), 32'd0);
        iVS = 1'b1; wr_en = 1'b0;
        cycle();
        chk("edge_req_still_pending", 32'(commit_pending), 32'd1);
        iVS = 1'b0; wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'h22;
        cycle();
        chk("copy_cycle_done", 32'(commit_done), 32'd1);
        chk("copy_cycle_score_old", score, 32'h11);
        iVS = 1'b1; wr_en = 1'b0; rd_addr = 4'd8;
        cycle();
        chk("copy_cycle_shadow_new", rd_data, 32'h22);

        // Reset in PENDING discards the request.
        do_reset();
        write(4'd0, 32'h7);
        write(4'd12, 32'h0);
        chk("pre_reset_pending", 32'(commit_pending), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        frame();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_reset_no_done", 32'(commit_done), 32'd0);
        end
        chk("post_reset_block1x", block1x, 32'd0);
        chk("post_reset_screenMode", screenMode, 32'd0);
        chk("post_reset_frame_count", 32'(frame_count), 32'd1);

        // Randomized run against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) iVS = ~iVS;
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_addr = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0; wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
